// File: rtl/udp_rx_sched.sv
// udp_rx_sched: per-datagram controller for the UDP receive path.
// Qualifies each datagram announced by the MAC receive buffer (enable,
// destination port, length limits, FIFOC free space), runs the fs/fd
// handshake of the MAC-to-FIFOC byte mover for accepted datagrams, releases
// the MAC buffer after every datagram and keeps ok/drop/timeout statistics.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   udp_rx_done     1-cycle pulse, datagram available (len/dport valid with it)
//   udp_rx_len      UDP length including the 8-byte header
//   udp_rx_dport    UDP destination port
//   cfg_en/cfg_port receive enable and accepted destination port
//   fifoc_free      free bytes in the FIFOC
//   mover_fs/fd     byte mover start (level) / done (level)
//   udp_rx_release  1-cycle pulse, MAC buffer may be reused
//   busy            high whenever the controller is not idle
//   pkt_ok_cnt      datagrams moved (saturating)
//   pkt_drop_cnt    datagrams dropped (saturating)
//   err_timeout     sticky, a mover timeout occurred
//   clr_stat        clears all statistics, wins over same-cycle updates
module udp_rx_sched #(
    parameter int MAX_PAYLOAD = 1024,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        udp_rx_done,
    input  logic [15:0] udp_rx_len,
    input  logic [15:0] udp_rx_dport,
    input  logic        cfg_en,
    input  logic [15:0] cfg_port,
    input  logic [11:0] fifoc_free,
    output logic        mover_fs,
    input  logic        mover_fd,
    output logic        udp_rx_release,
    output logic        busy,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_drop_cnt,
    output logic        err_timeout,
    input  logic        clr_stat
);

    localparam logic [15:0] MAX_PAY  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_WAITSPACE = 3'd2,
        S_WAIT_FD   = 3'd3,
        S_FINISH    = 3'd4,
        S_RELEASE   = 3'd5
    } state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] dport_q;
    logic [15:0] pay_q;
    logic [15:0] tmo_q;
    logic        ok_q;
    logic        fs_q;
    logic        rel_q;
    logic        busy_q;
    logic [15:0] ok_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        tmo_err_q;

    logic [15:0] pay_s;
    logic        filt_drop_s;
    logic        space_ok_s;
    logic        tmo_last_s;
    logic        ok_inc_s;
    logic [1:0]  drop_inc_s;
    logic        tmo_set_s;
    logic [15:0] ok_cnt_d;
    logic [15:0] drop_cnt_d;

    // Counter increment of 0..2 that sticks at 0xFFFF.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        sat_add = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Datagram qualification, space and timeout conditions, statistic updates.
    always_comb begin
        pay_s       = len_q - 16'd8;
        filt_drop_s = !cfg_en || (dport_q != cfg_port) || (len_q < 16'd9) || (pay_s > MAX_PAY);
        space_ok_s  = ({4'd0, fifoc_free} >= pay_q);
        tmo_last_s  = (tmo_q == TMO_LAST);
        ok_inc_s    = (state_q == S_RELEASE) && ok_q;
        // A RELEASE drop and an ignored done in the same cycle count twice.
        drop_inc_s  = {1'b0, (state_q == S_RELEASE) && !ok_q}
                    + {1'b0, udp_rx_done && (state_q != S_IDLE)};
        tmo_set_s   = (state_q == S_WAIT_FD) && !mover_fd && tmo_last_s;
        ok_cnt_d    = sat_add(ok_cnt_q, {1'b0, ok_inc_s});
        drop_cnt_d  = sat_add(drop_cnt_q, drop_inc_s);
    end

    // Datagram FSM with registered handshake, release and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            dport_q <= 16'd0;
            pay_q   <= 16'd0;
            tmo_q   <= 16'd0;
            ok_q    <= 1'b0;
            fs_q    <= 1'b0;
            rel_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rel_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tmo_q <= 16'd0;
                    if (udp_rx_done) begin
                        len_q   <= udp_rx_len;
                        dport_q <= udp_rx_dport;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    pay_q <= pay_s;
                    tmo_q <= 16'd0;
                    if (filt_drop_s) begin
                        ok_q    <= 1'b0;
                        rel_q   <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        state_q <= S_WAITSPACE;
                    end
                end
                S_WAITSPACE: begin
                    if (space_ok_s) begin
                        tmo_q   <= 16'd0;
                        fs_q    <= 1'b1;
                        state_q <= S_WAIT_FD;
                    end else if (tmo_last_s) begin
                        tmo_q   <= 16'd0;
                        ok_q    <= 1'b0;
                        rel_q   <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_WAIT_FD: begin
                    if (mover_fd) begin
                        tmo_q   <= 16'd0;
                        fs_q    <= 1'b0;
                        ok_q    <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (tmo_last_s) begin
                        tmo_q   <= 16'd0;
                        fs_q    <= 1'b0;
                        ok_q    <= 1'b0;
                        state_q <= S_FINISH;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_FINISH: begin
                    tmo_q <= 16'd0;
                    // The mover must drop fd before the buffer is handed back.
                    if (!mover_fd) begin
                        rel_q   <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        state_q <= S_FINISH;
                    end
                end
                S_RELEASE: begin
                    tmo_q   <= 16'd0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    tmo_q   <= 16'd0;
                    fs_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Statistics: saturating counters and sticky timeout, clr_stat has priority.
    always_ff @(posedge clk) begin
        if (rst || clr_stat) begin
            ok_cnt_q   <= 16'd0;
            drop_cnt_q <= 16'd0;
            tmo_err_q  <= 1'b0;
        end else begin
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            tmo_err_q  <= tmo_err_q | tmo_set_s;
        end
    end

    assign mover_fs       = fs_q;
    assign udp_rx_release = rel_q;
    assign busy           = busy_q;
    assign pkt_ok_cnt     = ok_cnt_q;
    assign pkt_drop_cnt   = drop_cnt_q;
    assign err_timeout    = tmo_err_q;

endmodule

// File: tb/tb_udp_rx_sched.sv
module tb_udp_rx_sched;

    localparam int T    = 20;
    localparam int MAXP = 1024;

    logic        clk;
    logic        rst;
    logic        udp_rx_done;
    logic [15:0] udp_rx_len;
    logic [15:0] udp_rx_dport;
    logic        cfg_en;
    logic [15:0] cfg_port;
    logic [11:0] fifoc_free;
    logic        mover_fs;
    logic        mover_fd;
    logic        udp_rx_release;
    logic        busy;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_drop_cnt;
    logic        err_timeout;
    logic        clr_stat;

    udp_rx_sched #(.MAX_PAYLOAD(MAXP), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .udp_rx_done(udp_rx_done), .udp_rx_len(udp_rx_len),
        .udp_rx_dport(udp_rx_dport), .cfg_en(cfg_en), .cfg_port(cfg_port),
        .fifoc_free(fifoc_free), .mover_fs(mover_fs), .mover_fd(mover_fd),
        .udp_rx_release(udp_rx_release), .busy(busy), .pkt_ok_cnt(pkt_ok_cnt),
        .pkt_drop_cnt(pkt_drop_cnt), .err_timeout(err_timeout), .clr_stat(clr_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scoreboard: one entry per datagram that must produce a release pulse,
    // holding whether the mover start must have been seen for it.
    bit sb_q[$];
    bit sb_en = 1'b1;
    bit fs_seen = 1'b0;

    int ok_m = 0;
    int drop_m = 0;
    int tmo_m = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fs_seen = 1'b0;
        end else begin
            if (mover_fs) fs_seen = 1'b1;
            if (udp_rx_release) begin
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_release", 1, 0);
                    end else begin
                        check("sb_fs_seen", int'(fs_seen), int'(sb_q.pop_front()));
                    end
                end
                fs_seen = 1'b0;
            end
        end
    end

    typedef struct {
        bit          en;
        logic [15:0] len;
        logic [15:0] dport;
        logic [11:0] free0;
        logic [11:0] free1;
        int          sw;       // tick after which free1 applies (0 = never)
        int          fd_delay; // ticks after fs rises before fd (-1 = never)
        int          e_fs_lat;
        int          e_fs_len;
        int          e_rel_lat;
        bit          e_ok;
        bit          e_tmo;
    } vec_t;

    vec_t vecs[12];

    task automatic run_dgram(input vec_t v, output int fs_lat, output int fs_len, output int rel_lat);
        int fell_at;
        fs_lat = 0; fs_len = 0; rel_lat = 0; fell_at = 0;
        cfg_en = v.en;
        fifoc_free = v.free0;
        udp_rx_len = v.len;
        udp_rx_dport = v.dport;
        udp_rx_done = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            udp_rx_done = 1'b0;
            if (mover_fs) begin
                if (fs_lat == 0) fs_lat = n;
                fs_len++;
            end else if (fs_lat != 0 && fell_at == 0) begin
                fell_at = n;
            end
            if (v.sw != 0 && n == v.sw) fifoc_free = v.free1;
            if (v.fd_delay >= 0 && fs_lat != 0 && n == fs_lat + v.fd_delay) mover_fd = 1'b1;
            if (fell_at != 0 && n == fell_at + 1) mover_fd = 1'b0;
            if (udp_rx_release) begin
                rel_lat = n;
                break;
            end
        end
        mover_fd = 1'b0;
        cfg_en = 1'b1;
    endtask

    initial begin
        int fl, fn, rl, n;
        rst = 1'b1; udp_rx_done = 1'b0; udp_rx_len = 16'd0; udp_rx_dport = 16'd0;
        cfg_en = 1'b1; cfg_port = 16'h1F90; fifoc_free = 12'd0; mover_fd = 1'b0; clr_stat = 1'b0;

        vecs[0]  = '{1'b1, 16'd72,   16'h1F90, 12'd100,  12'd0,  0,  5,  3,  6, 11, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 16'd72,   16'h1F91, 12'd100,  12'd0,  0,  0,  0,  0,  2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'd8,    16'h1F90, 12'd100,  12'd0,  0,  0,  0,  0,  2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'd1033, 16'h1F90, 12'd2000, 12'd0,  0,  0,  0,  0,  2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 16'd1032, 16'h1F90, 12'd1100, 12'd0,  0,  0,  3,  1,  6, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 16'd9,    16'h1F90, 12'd1,    12'd0,  0,  2,  3,  3,  8, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 16'd72,   16'h1F90, 12'd40,   12'd64, 12, 0, 13,  1, 16, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 16'd72,   16'h1F90, 12'd40,   12'd0,  0,  0,  0,  0, T+2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'd72,   16'h1F90, 12'd64,   12'd0,  0,  1,  3,  2,  7, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'd73,   16'h1F90, 12'd64,   12'd0,  0,  0,  0,  0, T+2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'd72,   16'h1F90, 12'd100,  12'd0,  0,  0,  0,  0,  2, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'd72,   16'h1F90, 12'd100,  12'd0,  0, -1,  3,  T, T+4, 1'b0, 1'b1};

        tick(); tick();
        check("rst_fs", int'(mover_fs), 0);
        check("rst_rel", int'(udp_rx_release), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ok", int'(pkt_ok_cnt), 0);
        check("rst_drop", int'(pkt_drop_cnt), 0);
        check("rst_tmo", int'(err_timeout), 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].e_fs_lat != 0);
            run_dgram(vecs[i], fl, fn, rl);
            check($sformatf("v%0d_fs_lat", i), fl, vecs[i].e_fs_lat);
            check($sformatf("v%0d_fs_len", i), fn, vecs[i].e_fs_len);
            check($sformatf("v%0d_rel_lat", i), rl, vecs[i].e_rel_lat);
            tick();
            if (vecs[i].e_ok) ok_m++; else drop_m++;
            if (vecs[i].e_tmo) tmo_m = 1;
            check($sformatf("v%0d_rel_one_cycle", i), int'(udp_rx_release), 0);
            check($sformatf("v%0d_idle", i), int'(busy), 0);
            check($sformatf("v%0d_ok_cnt", i), int'(pkt_ok_cnt), ok_m);
            check($sformatf("v%0d_drop_cnt", i), int'(pkt_drop_cnt), drop_m);
            check($sformatf("v%0d_tmo", i), int'(err_timeout), tmo_m);
        end

        // clr_stat clears everything
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        ok_m = 0; drop_m = 0; tmo_m = 0;
        check("clr_ok", int'(pkt_ok_cnt), 0);
        check("clr_drop", int'(pkt_drop_cnt), 0);
        check("clr_tmo", int'(err_timeout), 0);

        // Second done during WAIT_FD, cfg change mid-datagram
        fifoc_free = 12'd100; udp_rx_len = 16'd72; udp_rx_dport = 16'h1F90;
        sb_q.push_back(1'b1);
        udp_rx_done = 1'b1; tick(); udp_rx_done = 1'b0; tick(); tick();
        check("a_fs_high", int'(mover_fs), 1);
        cfg_port = 16'h0001; cfg_en = 1'b0;
        udp_rx_dport = 16'h1234; udp_rx_done = 1'b1; tick(); udp_rx_done = 1'b0;
        drop_m++;
        check("a_ignored_drop", int'(pkt_drop_cnt), drop_m);
        check("a_still_fs", int'(mover_fs), 1);
        mover_fd = 1'b1; tick();
        check("a_fs_fall", int'(mover_fs), 0);
        mover_fd = 1'b0; tick();
        check("a_release", int'(udp_rx_release), 1);
        tick(); ok_m++;
        check("a_ok_cnt", int'(pkt_ok_cnt), ok_m);
        cfg_port = 16'h1F90; cfg_en = 1'b1;

        // Done during a drop's RELEASE counts twice; done right after is accepted
        udp_rx_dport = 16'h0BAD; sb_q.push_back(1'b0);
        udp_rx_done = 1'b1; tick(); udp_rx_done = 1'b0; tick();
        check("b_release", int'(udp_rx_release), 1);
        udp_rx_done = 1'b1; tick(); udp_rx_done = 1'b0;
        drop_m += 2;
        check("b_plus2", int'(pkt_drop_cnt), drop_m);
        sb_q.push_back(1'b0);
        udp_rx_done = 1'b1; tick(); udp_rx_done = 1'b0;
        check("b_accept_busy", int'(busy), 1);
        tick();
        check("b_release2", int'(udp_rx_release), 1);
        tick(); drop_m++;
        check("b_drop_cnt", int'(pkt_drop_cnt), drop_m);

        // Reset while in WAIT_FD
        udp_rx_dport = 16'h1F90;
        udp_rx_done = 1'b1; tick(); udp_rx_done = 1'b0; tick(); tick();
        check("c_fs_high", int'(mover_fs), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        ok_m = 0; drop_m = 0;
        check("c_fs", int'(mover_fs), 0);
        check("c_busy", int'(busy), 0);
        check("c_rel", int'(udp_rx_release), 0);
        check("c_ok", int'(pkt_ok_cnt), 0);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (udp_rx_release) n++;
        end
        check("c_no_release", n, 0);

        // Saturation through continuous filtered drops
        sb_en = 1'b0;
        udp_rx_dport = 16'h0BAD; udp_rx_done = 1'b1;
        for (int k = 0; k < 70000 && pkt_drop_cnt !== 16'hFFFF; k++) tick();
        check("d_reach_sat", int'(pkt_drop_cnt), 16'hFFFF);
        repeat (9) tick();
        udp_rx_done = 1'b0;
        for (int k = 0; k < 10 && busy; k++) tick();
        tick();
        check("d_stay_sat", int'(pkt_drop_cnt), 16'hFFFF);
        check("d_ok_zero", int'(pkt_ok_cnt), 0);
        check("d_idle", int'(busy), 0);
        sb_en = 1'b1;

        // clr_stat coincident with RELEASE
        sb_q.push_back(1'b0);
        udp_rx_done = 1'b1; tick(); udp_rx_done = 1'b0; tick();
        check("e_release", int'(udp_rx_release), 1);
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        check("e_drop_zero", int'(pkt_drop_cnt), 0);
        check("e_ok_zero", int'(pkt_ok_cnt), 0);
        check("e_tmo_zero", int'(err_timeout), 0);

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
